// File: rtl/capture_timer_ctrl.sv
// Per-channel start-to-capture interval timers with a round-robin result scheduler.
// Define CAPTURE_TIMER_OVF_EN to build saturating counters with a per-channel overflow flag.
module capture_timer_ctrl #(
  parameter int unsigned NB_CAPTURES = 10,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned CH_W       = (NB_CAPTURES > 1) ? $clog2(NB_CAPTURES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic [NB_CAPTURES-1:0] start_rise_i,
  input  logic [NB_CAPTURES-1:0] capture_rise_i,
  input  logic [NB_CAPTURES-1:0] rst_capture_rise_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [CH_W-1:0]        res_ch_o,
  output logic [CNT_W-1:0]       res_cnt_o,
  output logic                   res_ovf_o,
  output logic [NB_CAPTURES-1:0] busy_o,
  output logic [NB_CAPTURES-1:0] pending_o,
  output logic                   miss_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam int unsigned    ArbW   = CH_W + 1;
  localparam logic [ArbW-1:0] NbW   = ArbW'(NB_CAPTURES);
  localparam logic [CH_W-1:0] LastCh = CH_W'(NB_CAPTURES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q [NB_CAPTURES];
  logic [1:0]       state_d [NB_CAPTURES];
  logic [CNT_W-1:0] cnt_q   [NB_CAPTURES];
  logic [CNT_W-1:0] cnt_d   [NB_CAPTURES];

  logic [NB_CAPTURES-1:0] run_vec;
  logic [NB_CAPTURES-1:0] hold_vec;
  logic [NB_CAPTURES-1:0] req;

  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] gnt_idx;
  logic [ArbW-1:0] arb_idx;
  logic            gnt_valid;
  logic            load;

  logic             res_valid_q, res_valid_d;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             miss_q, miss_d;

`ifdef CAPTURE_TIMER_OVF_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  logic [NB_CAPTURES-1:0] ovf_q, ovf_d;
  logic                   res_ovf_q, res_ovf_d;
`endif

  always_comb begin
    for (int c = 0; c < NB_CAPTURES; c++) begin
      run_vec[c]  = (state_q[c] == StRun);
      hold_vec[c] = (state_q[c] == StHold);
    end
  end

  // An abort in the grant cycle removes the channel from arbitration, so another wins.
  assign req  = hold_vec & ~rst_capture_rise_i;
  assign load = gnt_valid && (!res_valid_q || res_ready_i);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NB_CAPTURES; i++) begin
      arb_idx = {1'b0, rr_q} + ArbW'(i);
      if (arb_idx >= NbW) begin
        arb_idx = arb_idx - NbW;
      end
      if (!gnt_valid && req[arb_idx[CH_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (load) begin
      rr_d = (gnt_idx == LastCh) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  // Channel FSMs: abort beats capture beats start. A held channel's counter is frozen
  // and doubles as its pending result.
  always_comb begin
`ifdef CAPTURE_TIMER_OVF_EN
    ovf_d = ovf_q;
`endif
    for (int c = 0; c < NB_CAPTURES; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (rst_capture_rise_i[c]) begin
        state_d[c] = StIdle;
        cnt_d[c]   = '0;
`ifdef CAPTURE_TIMER_OVF_EN
        ovf_d[c]   = 1'b0;
`endif
      end else begin
        case (state_q[c])
          StIdle: begin
            if (start_rise_i[c]) begin
              state_d[c] = StRun;
              cnt_d[c]   = CntOne;
`ifdef CAPTURE_TIMER_OVF_EN
              ovf_d[c]   = 1'b0;
`endif
            end
          end
          StRun: begin
            if (capture_rise_i[c]) begin
              state_d[c] = StHold;
            end else if (start_rise_i[c]) begin
              cnt_d[c] = CntOne;
`ifdef CAPTURE_TIMER_OVF_EN
              ovf_d[c] = 1'b0;
`endif
            end else begin
`ifdef CAPTURE_TIMER_OVF_EN
              if (cnt_q[c] == CntMax) begin
                ovf_d[c] = 1'b1;
              end else begin
                cnt_d[c] = cnt_q[c] + CntOne;
              end
`else
              cnt_d[c] = cnt_q[c] + CntOne;
`endif
            end
          end
          StHold: begin
            if (load && (gnt_idx == CH_W'(c))) begin
              state_d[c] = StIdle;
              cnt_d[c]   = '0;
            end
          end
          default: begin
            state_d[c] = StIdle;
            cnt_d[c]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_cnt_d   = res_cnt_q;
`ifdef CAPTURE_TIMER_OVF_EN
    res_ovf_d   = res_ovf_q;
`endif
    if (load) begin
      res_valid_d = 1'b1;
      res_ch_d    = gnt_idx;
      res_cnt_d   = cnt_q[gnt_idx];
`ifdef CAPTURE_TIMER_OVF_EN
      res_ovf_d   = ovf_q[gnt_idx];
`endif
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  assign miss_d = |(hold_vec & capture_rise_i & ~rst_capture_rise_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NB_CAPTURES; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
      end
      rr_q        <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_cnt_q   <= '0;
      miss_q      <= 1'b0;
    end else if (clr_i) begin
      for (int c = 0; c < NB_CAPTURES; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
      end
      rr_q        <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_cnt_q   <= '0;
      miss_q      <= 1'b0;
    end else begin
      for (int c = 0; c < NB_CAPTURES; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      rr_q        <= rr_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_cnt_q   <= res_cnt_d;
      miss_q      <= miss_d;
    end
  end

`ifdef CAPTURE_TIMER_OVF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q     <= '0;
      res_ovf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign res_ovf_o = res_ovf_q;
`else
  assign res_ovf_o = 1'b0;
`endif

  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_cnt_o   = res_cnt_q;
  assign busy_o      = run_vec;
  assign pending_o   = hold_vec;
  assign miss_o      = miss_q;

endmodule

// File: doc/capture_timer_ctrl.md
# capture_timer_ctrl

Per-channel interval timer and result scheduler that consumes the rising-edge pulses produced by the capture edge detector. Each of NB_CAPTURES channels measures the clock cycles from a start edge to a capture edge. A single round-robin arbiter serialises the completed measurements onto one valid/ready result port for the downstream register/readout logic.

## Interface
- NB_CAPTURES, 10, number of channels; derived CH_W = max(1, clog2(NB_CAPTURES))
- CNT_W, 16, interval counter / result width
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- clr_i  in  1  synchronous clear, same effect as reset
- start_rise_i  in  NB_CAPTURES  one-cycle start edge pulse per channel
- capture_rise_i  in  NB_CAPTURES  one-cycle capture edge pulse per channel
- rst_capture_rise_i  in  NB_CAPTURES  one-cycle channel abort pulse
- res_valid_o  out  1  result register holds a result
- res_ready_i  in  1  consumer accepts the result when high together with res_valid_o
- res_ch_o  out  CH_W  channel index of the result
- res_cnt_o  out  CNT_W  measured interval in cycles
- res_ovf_o  out  1  interval exceeded counter range (see Configuration)
- busy_o  out  NB_CAPTURES  channel in RUN
- pending_o  out  NB_CAPTURES  channel in HOLD
- miss_o  out  1  registered one-cycle pulse: at least one capture was dropped because its channel was in HOLD

## Operation
- Per-channel FSM with states IDLE, RUN and HOLD. Priority per cycle: rst_capture, then capture, then start.
- Any state with rst_capture: go to IDLE; clear the counter and the pending result. A result already loaded into the output register is unaffected.
- IDLE with start: go to RUN, cnt <= 1. A capture in IDLE is ignored; no miss.
- RUN: cnt increments every cycle.
  - Capture (including capture and start in the same cycle): go to HOLD, latch result = cnt.
  - Start alone: restart, cnt <= 1.
- HOLD: start is ignored. A capture is dropped and raises miss_o in the next cycle. The channel goes to IDLE in the cycle its result is loaded into the output register.
- Result semantics: start in cycle T0 and capture in cycle T1 give res_cnt_o = T1 - T0 (minimum 1).
- Output register loads when (!res_valid_o || res_ready_i) and at least one channel is in HOLD.
- Round-robin arbiter:
  - The search starts at pointer rr.
  - Grant to channel k sets rr <= k+1, wrapping from NB_CAPTURES-1 to 0.
  - rr stays unchanged when nothing is granted.
- res_valid_o stays high and res_* stay stable until accepted. Back-to-back loads give one result per cycle.
- Reset/clr values: all FSMs IDLE, all counters 0, rr = 0, res_valid_o = 0, res_ch_o = 0, res_cnt_o = 0, res_ovf_o = 0, miss_o = 0, busy_o = 0, pending_o = 0.
- Reset asserted mid-operation discards every measurement and the held result.

## Timing
- Capture pulse in cycle T1: pending_o high from T1+1; res_valid_o high from T1+2 if the output register is free.
- busy_o and pending_o are decoded directly from FSM state registers; no extra latency.
- A result accepted in cycle A (res_valid_o && res_ready_i) lets the next pending result appear at A+1.
- rst_capture in the same cycle as a grant to that channel: the grant is suppressed, the channel goes to IDLE, and the arbiter picks another HOLD channel in that cycle.

## Configuration
- CAPTURE_TIMER_OVF_EN defined:
  - Channel counters saturate at 2^CNT_W-1 and set a per-channel overflow flag.
  - The flag is cleared on start and on rst_capture.
  - The flag is latched with the result and driven on res_ovf_o.
- CAPTURE_TIMER_OVF_EN undefined:
  - Counters wrap modulo 2^CNT_W.
  - No overflow flag logic is built; res_ovf_o is tied to 0.

## Test plan
- Start ch3 at cycle 10, capture ch3 at cycle 52, res_ready_i = 1 -> res_valid_o at cycle 54 with res_ch_o = 3, res_cnt_o = 42; pending_o[3] high cycle 53 only.
- Captures on ch0, ch5 and ch9 in the same cycle, all running, res_ready_i = 1 -> results on three consecutive cycles in order 0, 5, 9; second round starting at rr = 0 (after wrap) -> order 0, 5, 9 again.
- res_ready_i = 0 for 20 cycles with one result held -> res_* stable. A second capture on the held-result channel after it restarted -> held. A third capture while that channel is in HOLD -> miss_o pulses once.
- Start and capture in the same cycle on an IDLE channel -> channel enters RUN, no result. Same pair while in RUN -> result latched and channel enters HOLD.
- rst_capture on ch2 while in HOLD with output blocked -> pending_o[2] = 0 next cycle and no ch2 result is ever emitted. Assert rst_i mid-RUN -> all outputs return to their reset values asynchronously.
- CNT_W = 4, capture 20 cycles after start -> with CAPTURE_TIMER_OVF_EN: res_cnt_o = 15, res_ovf_o = 1. Without it: res_cnt_o = 4, res_ovf_o = 0.
